ext_adc_scheduler: RTL

- Shares one external ADC (AdcDoConvert/AdcConvComplete/AdcValue) between NUM_REQ sensor apps that each expect a private ADC start/done handshake.
- Round-robin arbitration, one conversion at a time, per-requester done pulse, programmable guard gap between conversions, conversion timeout.
- Sits between the reconfigurable-module app slots and the ADC pins.

---
 rtl/ext_adc_pkg.sv | 14 +
 rtl/ext_adc_rr_pick.sv | 26 ++
 rtl/ext_adc_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ext_adc_pkg.sv
// Shared types and defaults for the external ADC scheduler.
// The state encoding is visible here so tools and neighbours agree on it.
package ext_adc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      GUARD   = 2'd2
   } state_e;

   localparam int DEFAULT_NUM_REQ = 4;
   localparam int DEFAULT_DATA_W  = 16;

endpackage

// File: rtl/ext_adc_rr_pick.sv
// Combinational round-robin picker: the first set request strictly after Pointer_i,
// wrapping around, is returned one-hot.
module ext_adc_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] Req_i,
   input  logic [PTR_W-1:0]   Pointer_i,
   output logic [NUM_REQ-1:0] Pick_o,
   output logic               AnyReq_o
);

   logic [NUM_REQ-1:0] upper_mask;
   logic [NUM_REQ-1:0] masked;
   logic [NUM_REQ-1:0] src;

   // Keep only bits above the pointer; fall back to the full vector to wrap.
   always_comb begin
      upper_mask = ~((NUM_REQ'(2) << Pointer_i) - NUM_REQ'(1));
      masked     = Req_i & upper_mask;
      src        = (masked != '0) ? masked : Req_i;
      Pick_o     = src & (~src + NUM_REQ'(1));
      AnyReq_o   = |Req_i;
   end

endmodule

// File: rtl/ext_adc_scheduler.sv
// Shares one external ADC between NUM_REQ apps: round-robin grant, one conversion
// at a time, per-owner done/timeout pulses and a programmable guard gap.
module ext_adc_scheduler
   import ext_adc_pkg::*;
#(
   parameter int NUM_REQ = DEFAULT_NUM_REQ,
   parameter int DATA_W  = DEFAULT_DATA_W
) (
   input  logic               Clk_i,
   input  logic               Reset_i,
   input  logic [NUM_REQ-1:0] Req_i,
   output logic [NUM_REQ-1:0] Grant_o,
   output logic [NUM_REQ-1:0] Done_o,
   output logic [NUM_REQ-1:0] Timeout_o,
   output logic [DATA_W-1:0]  Value_o,
   output logic               Busy_o,
   output logic               AdcStart_o,
   input  logic               AdcDone_i,
   input  logic [DATA_W-1:0]  AdcValue_i,
   input  logic [7:0]         GuardCycles_i,
   input  logic [15:0]        TimeoutPreset_i
);

   localparam int PTR_W = $clog2(NUM_REQ);

   state_e             state_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [NUM_REQ-1:0] done_q;
   logic [NUM_REQ-1:0] timeout_q;
   logic [DATA_W-1:0]  value_q;
   logic               busy_q;
   logic               start_q;
   logic [PTR_W-1:0]   ptr_q;
   logic [PTR_W-1:0]   gidx_q;
   logic [15:0]        tmo_cnt_q;
   logic [7:0]         guard_cnt_q;

   logic [NUM_REQ-1:0] pick;
   logic               any_req;
   logic [PTR_W-1:0]   pick_idx;
   logic               owner_req;
   logic               conv_end;

   ext_adc_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .Req_i     (Req_i),
      .Pointer_i (ptr_q),
      .Pick_o    (pick),
      .AnyReq_o  (any_req)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) pick_idx = PTR_W'(i);
      end
   end

   // A zero counter means the timeout is disabled, so only a loaded preset can reach 1.
   assign owner_req = (Req_i & grant_q) != '0;
   assign conv_end  = (state_q == CONVERT) &&
                      (AdcDone_i || !owner_req || (tmo_cnt_q == 16'd1));

   always_ff @(posedge Clk_i) begin
      if (Reset_i) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         done_q      <= '0;
         timeout_q   <= '0;
         value_q     <= '0;
         busy_q      <= 1'b0;
         start_q     <= 1'b0;
         ptr_q       <= PTR_W'(NUM_REQ - 1);
         gidx_q      <= '0;
         tmo_cnt_q   <= '0;
         guard_cnt_q <= '0;
      end else begin
         done_q    <= '0;
         timeout_q <= '0;
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  grant_q   <= pick;
                  gidx_q    <= pick_idx;
                  start_q   <= 1'b1;
                  busy_q    <= 1'b1;
                  tmo_cnt_q <= TimeoutPreset_i;
                  state_q   <= CONVERT;
               end
            end
            CONVERT: begin
               if (conv_end) begin
                  grant_q     <= '0;
                  start_q     <= 1'b0;
                  ptr_q       <= gidx_q;
                  guard_cnt_q <= GuardCycles_i;
                  // Done beats both abort and timeout when they coincide.
                  if (AdcDone_i) begin
                     value_q <= AdcValue_i;
                     done_q  <= grant_q;
                  end else if (owner_req) begin
                     timeout_q <= grant_q;
                  end
                  if (GuardCycles_i == 8'd0) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= GUARD;
                  end
               end else if (tmo_cnt_q != 16'd0) begin
                  tmo_cnt_q <= tmo_cnt_q - 16'd1;
               end
            end
            GUARD: begin
               guard_cnt_q <= guard_cnt_q - 8'd1;
               if (guard_cnt_q <= 8'd1) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Grant_o    = grant_q;
   assign Done_o     = done_q;
   assign Timeout_o  = timeout_q;
   assign Value_o    = value_q;
   assign Busy_o     = busy_q;
   assign AdcStart_o = start_q;

endmodule
